mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serialising memory controller arbitrating IF and MEM onto one RAM port
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic [2:0]        len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       acc_q;
  logic              own_mem_q;

  logic              grant_mem;
  logic              grant_if;
  logic [2:0]        beat;
  logic [1:0]        rd_idx;
  logic              last;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        wbyte;
  logic [31:0]       acc_d;
  logic [2:0]        mem_len_n;

  // A port in its done cycle is dropping its request, so it must not win again.
  assign grant_mem = mem_req_i && !mem_done_o;
  assign grant_if  = if_req_i && !if_done_o;

  // beat is the index of the edge being taken relative to the grant edge.
  assign beat      = cnt_q + 3'd1;
  assign rd_idx    = cnt_q[1:0] - 2'd1;
  assign last      = (beat == len_q + 3'd1);
  assign next_addr = addr_q + {{(ADDR_W-3){1'b0}}, beat};
  assign wbyte     = wdata_q[{beat[1:0], 3'b000} +: 8];
  assign mem_len_n = (mem_len_i == 2'd0) ? 3'd1 : (mem_len_i == 2'd1) ? 3'd2 : 3'd4;

  always_comb begin
    acc_d = acc_q;
    if (cnt_q != 3'd0) begin
      acc_d[{rd_idx, 3'b000} +: 8] = ram_din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      acc_q       <= 32'd0;
      own_mem_q   <= 1'b0;
      if_data_o   <= 32'd0;
      if_done_o   <= 1'b0;
      mem_rdata_o <= 32'd0;
      mem_done_o  <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_a_o     <= '0;
      ram_dout_o  <= 8'd0;
      busy_o      <= 1'b0;
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_mem || grant_if) begin
            busy_o    <= 1'b1;
            cnt_q     <= 3'd0;
            acc_q     <= 32'd0;
            own_mem_q <= grant_mem;
            addr_q    <= grant_mem ? mem_addr_i : if_addr_i;
            ram_a_o   <= grant_mem ? mem_addr_i : if_addr_i;
            len_q     <= grant_mem ? mem_len_n : 3'd4;
            wdata_q   <= mem_wdata_i;
            if (grant_mem && mem_we_i) begin
              state_q    <= WR;
              ram_we_o   <= 1'b1;
              ram_dout_o <= mem_wdata_i[7:0];
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: begin
          cnt_q   <= cnt_q + 3'd1;
          acc_q   <= acc_d;
          ram_a_o <= (beat < len_q) ? next_addr : '0;
          if (last) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
            if (own_mem_q) begin
              mem_rdata_o <= acc_d;
              mem_done_o  <= 1'b1;
            end else begin
              if_data_o <= acc_d;
              if_done_o <= 1'b1;
            end
          end
        end
        WR: begin
          cnt_q <= cnt_q + 3'd1;
          if (beat < len_q) begin
            ram_we_o   <= 1'b1;
            ram_a_o    <= next_addr;
            ram_dout_o <= wbyte;
          end else begin
            ram_we_o   <= 1'b0;
            ram_a_o    <= '0;
            ram_dout_o <= 8'd0;
          end
          if (last) begin
            state_q    <= IDLE;
            busy_o     <= 1'b0;
            mem_done_o <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a byte-array memory model
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_done_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_len_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;
  logic        ram_we_o;
  logic [31:0] ram_a_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i;
  logic        busy_o;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .ram_we_o(ram_we_o), .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  logic [7:0]  ram   [bit [31:0]];
  logic [7:0]  model [bit [31:0]];
  logic [31:0] exp_if_data  = 32'd0;
  logic [31:0] exp_mem_data = 32'd0;

  function automatic logic [7:0] fill(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_get(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : fill(a);
  endfunction

  function automatic logic [7:0] model_get(input logic [31:0] a);
    return model.exists(a) ? model[a] : fill(a);
  endfunction

  // Byte-wide synchronous RAM: read data appears the cycle after its address.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we_o) ram[ram_a_o] = ram_dout_o;
    ram_din_i <= ram_get(ram_a_o);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic xact(input bit is_if, input bit we, input logic [1:0] len,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input bit solo, output int done_cyc);
    int n;
    int nb;
    bit done;
    logic [31:0] expd;
    nb   = is_if ? 4 : (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    expd = 32'd0;
    for (int i = 0; i < nb; i++) begin
      if (we) model[addr + i] = wdata[8*i +: 8];
      else    expd[8*i +: 8] = model_get(addr + i);
    end
    if (is_if) begin
      if_req_i = 1'b1; if_addr_i = addr;
    end else begin
      mem_req_i = 1'b1; mem_we_i = we; mem_len_i = len; mem_addr_i = addr; mem_wdata_i = wdata;
    end
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (solo && n <= nb + 1) begin
        chk("busy_beat", busy_o, 1);
        chk("we_beat", ram_we_o, we && n <= nb);
        chk("addr_beat", ram_a_o, (n <= nb) ? addr + n - 1 : 32'd0);
        if (we && n <= nb) chk("dout_beat", ram_dout_o, wdata[8*(n-1) +: 8]);
      end
      done = is_if ? if_done_o : mem_done_o;
    end
    done_cyc = cyc;
    chk("done_seen", done, 1);
    if (solo) begin
      chk("latency", n, nb + 2);
      chk("busy_turn", busy_o, 0);
    end
    if (is_if) begin
      exp_if_data = expd;
      chk("if_data", if_data_o, expd);
      if_req_i = 1'b0;
    end else begin
      if (!we) begin
        exp_mem_data = expd;
        chk("mem_rdata", mem_rdata_o, expd);
      end
      mem_req_i = 1'b0;
    end
  endtask

  initial begin
    int dm;
    int di;
    bit is_if;
    bit we;
    logic [31:0] a;

    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'd0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 2'd0; mem_addr_i = 32'd0; mem_wdata_i = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_we", ram_we_o, 0);
    chk("rst_a", ram_a_o, 0);
    chk("rst_dout", ram_dout_o, 0);
    chk("rst_ifd", if_data_o, 0);
    chk("rst_memd", mem_rdata_o, 0);
    chk("rst_done", {if_done_o, mem_done_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
    model[32'h100] = 8'h13; model[32'h101] = 8'h05; model[32'h102] = 8'h10; model[32'h103] = 8'h00;
    xact(1, 0, 2'd2, 32'h100, 0, 1, di);
    chk("if_word_val", if_data_o, 32'h00100513);
    @(negedge clk);
    xact(0, 1, 2'd2, 32'h2000, 32'hDEADBEEF, 1, dm);
    chk("sw_we_after", ram_we_o, 0);
    @(negedge clk);
    xact(0, 0, 2'd0, 32'h2003, 0, 1, dm);
    chk("lb_val", mem_rdata_o, 32'h000000DE);
    @(negedge clk);
    xact(0, 0, 2'd1, 32'h2002, 0, 1, dm);
    chk("lh_val", mem_rdata_o, 32'h0000DEAD);
    @(negedge clk);
    xact(0, 0, 2'd2, 32'hFFFFFFFE, 0, 1, dm);

    @(negedge clk);
    fork
      xact(0, 0, 2'd2, 32'h2000, 0, 0, dm);
      xact(1, 0, 2'd2, 32'h100, 0, 0, di);
    join
    chk("arb_gap", di - dm, 6);
    @(negedge clk);

    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'd2; mem_addr_i = 32'h3000; mem_wdata_i = 32'h11223344;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_we", ram_we_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_done", mem_done_o, 0);
    rst = 1'b0;
    mem_req_i = 1'b0;
    exp_if_data = 32'd0;
    exp_mem_data = 32'd0;
    @(negedge clk);
    chk("rst_mid_done2", mem_done_o, 0);
    chk("rst_mid_memd", mem_rdata_o, 0);
    xact(1, 0, 2'd2, 32'h100, 0, 1, di);
    @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      is_if = ($urandom_range(0, 2) == 0);
      we    = !is_if && $urandom_range(0, 1);
      a     = $urandom_range(0, 3) == 0 ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                       : 32'h2000 + $urandom_range(0, 63);
      xact(is_if, we, 2'($urandom_range(0, 3)), a, $urandom, 1, dm);
      chk("hold_if", if_data_o, exp_if_data);
      chk("hold_mem", mem_rdata_o, exp_mem_data);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
